register_bank: RTL and testbench

- Parametrised, fully synchronous control/status register bank for the memory-bus slave side of the video core.
- Successor to the asynchronous per-register flip-flop file; all state is clocked by the system clock.
- Per-register type is chosen by parameter masks: read-only, read/write, write-1-to-clear sticky status, or self-clearing pulse.
- Adds registered read data with a valid flag, per-register write strobes, and an interrupt summary output.

---
 rtl/register_bank.sv | 70 +++++++
 tb/tb_register_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: synchronous CSR bank with per-register RO/RW/W1C/PULSE types, registered reads and irq summary
module register_bank #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RW_MASK = 16'h0070,
  parameter logic [NUM_REGS-1:0] W1C_MASK = 16'h0000,
  parameter logic [NUM_REGS-1:0] PULSE_MASK = 16'h0000,
  parameter logic [DATA_WIDTH*NUM_REGS-1:0] RESET_VALUES = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic rd,
  input  logic wr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic rd_valid,
  input  logic [DATA_WIDTH*NUM_REGS-1:0] values_in,
  output logic [DATA_WIDTH*NUM_REGS-1:0] values_out,
  output logic [NUM_REGS-1:0] wr_strobe,
  output logic irq
);
  logic [DATA_WIDTH-1:0] bmask, rdata, data_out_q;
  logic [DATA_WIDTH-1:0] cur [NUM_REGS];
  logic [NUM_REGS-1:0] sel, w1c_any, rst_any, wr_strobe_q;
  logic in_range, wr_acc, rd_valid_q, irq_q;
  always_comb begin
    for (int k = 0; k < DATA_WIDTH/8; k++) bmask[8*k +: 8] = {8{be[k]}};
  end
  assign in_range = int'(addr) < NUM_REGS;
  assign wr_acc = en && wr && in_range;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [DATA_WIDTH-1:0] RST = RESET_VALUES[DATA_WIDTH*i +: DATA_WIDTH];
    logic [DATA_WIDTH-1:0] set_v;
    assign set_v = values_in[DATA_WIDTH*i +: DATA_WIDTH];
    assign sel[i] = wr_acc && addr == ADDR_WIDTH'(i);
    if (W1C_MASK[i] || PULSE_MASK[i] || RW_MASK[i]) begin : g_st
      logic [DATA_WIDTH-1:0] val_q, val_d;
      // W1C outranks PULSE, which outranks RW; W1C sets win over same-cycle clears
      assign val_d = W1C_MASK[i] ? (val_q & ~(sel[i] ? data_in & bmask : '0)) | set_v :
                     PULSE_MASK[i] ? (sel[i] ? data_in & bmask : '0) :
                     sel[i] ? (val_q & ~bmask) | (data_in & bmask) : val_q;
      always_ff @(posedge clk) val_q <= reset ? RST : val_d;
      assign cur[i] = val_q;
      if (!W1C_MASK[i]) begin : g_nset
        logic unused_set;
        assign unused_set = ^set_v;
      end
    end else begin : g_ro
      assign cur[i] = set_v;
    end
    assign values_out[DATA_WIDTH*i +: DATA_WIDTH] = cur[i];
    assign w1c_any[i] = W1C_MASK[i] && |cur[i];
    assign rst_any[i] = W1C_MASK[i] && |RST;
  end
  assign rdata = in_range ? cur[addr] : '0;
  always_ff @(posedge clk) begin
    rd_valid_q <= !reset && en && rd;
    data_out_q <= reset ? '0 : (en && rd) ? rdata : data_out_q;
    wr_strobe_q <= reset ? '0 : sel;
    irq_q <= reset ? |rst_any : |w1c_any;
  end
  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign wr_strobe = wr_strobe_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed and randomized checks of register_bank against an array-based reference model
module tb_register_bank;
  localparam int AW = 4, DW = 16, NR = 12;
  localparam logic [NR-1:0] RWM = 12'h1F0, W1M = 12'h084, PLM = 12'h108;
  localparam logic [DW*NR-1:0] RST = (192'h1111 << 96) | (192'h00A5 << 64);
  logic clk = 0, reset = 1, en = 0, rd = 0, wr = 0;
  logic [1:0] be = 0;
  logic [AW-1:0] addr = 0;
  logic [DW-1:0] data_in = 0, data_out;
  logic rd_valid, irq;
  logic [DW*NR-1:0] values_in = '0, values_out;
  logic [NR-1:0] wr_strobe;
  logic [DW-1:0] mdl [NR];
  logic [DW-1:0] exp_do = 0;
  logic exp_rv = 0, exp_irq = 0;
  logic [NR-1:0] exp_ws = 0;
  logic [DW*NR-1:0] rst_img = RST;
  int checks = 0, errors = 0;

  register_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RW_MASK(RWM),
    .W1C_MASK(W1M), .PULSE_MASK(PLM), .RESET_VALUES(RST)) dut (
    .clk(clk), .reset(reset), .en(en), .rd(rd), .wr(wr), .be(be), .addr(addr),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid), .values_in(values_in),
    .values_out(values_out), .wr_strobe(wr_strobe), .irq(irq));

  always #5 clk = ~clk;

  function automatic int kind(int i);
    return W1M[i] ? 2 : PLM[i] ? 3 : RWM[i] ? 1 : 0;
  endfunction

  function automatic logic [DW-1:0] cur_v(int i);
    return kind(i) == 0 ? values_in[DW*i +: DW] : mdl[i];
  endfunction

  function automatic logic [DW*NR-1:0] exp_vo();
    logic [DW*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[DW*i +: DW] = cur_v(i);
    return v;
  endfunction

  task automatic set(input logic e, r, w, input logic [1:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    en = e; rd = r; wr = w; be = b; addr = a; data_in = d;
  endtask

  // Advance one clock, first folding the current inputs into the reference model
  task automatic tick();
    logic [DW-1:0] m;
    logic any, hit;
    m = {{8{be[1]}}, {8{be[0]}}};
    any = 0;
    for (int i = 0; i < NR; i++)
      if (W1M[i] && (reset ? rst_img[DW*i +: DW] : mdl[i]) != 0) any = 1;
    exp_irq = any;
    exp_rv = !reset && en && rd;
    if (reset) exp_do = 0;
    else if (en && rd) exp_do = int'(addr) < NR ? cur_v(int'(addr)) : 16'h0;
    exp_ws = 0;
    for (int i = 0; i < NR; i++) begin
      hit = !reset && en && wr && int'(addr) == i;
      if (hit) exp_ws[i] = 1;
      if (reset) mdl[i] = rst_img[DW*i +: DW];
      else case (kind(i))
        1: if (hit) mdl[i] = (mdl[i] & ~m) | (data_in & m);
        2: mdl[i] = (mdl[i] & ~(hit ? data_in & m : 16'h0)) | values_in[DW*i +: DW];
        3: mdl[i] = hit ? data_in & m : 16'h0;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; set(0, 0, 0, 0, 0, 0); tick(); reset = 0;
    checks++; if (values_out[79:64] !== 16'h00A5) begin errors++; $display("FAIL reset_r4 got %h want 00a5", values_out[79:64]); end
    checks++; if (values_out[111:96] !== 16'h1111) begin errors++; $display("FAIL reset_r6 got %h want 1111", values_out[111:96]); end
    checks++; if (rd_valid !== 0 || data_out !== 0) begin errors++; $display("FAIL reset_rd got %b/%h want 0/0000", rd_valid, data_out); end
    checks++; if (irq !== 0 || wr_strobe !== 0) begin errors++; $display("FAIL reset_irq_ws got %b/%h want 0/000", irq, wr_strobe); end
  endtask

  task automatic test_byte_enable();
    set(1, 0, 1, 2'b10, 5, 16'hBEEF); tick();
    checks++; if (values_out[95:80] !== 16'hBE00) begin errors++; $display("FAIL be_write got %h want be00", values_out[95:80]); end
    checks++; if (wr_strobe !== 12'h020) begin errors++; $display("FAIL be_strobe got %h want 020", wr_strobe); end
    set(1, 1, 0, 0, 5, 0); tick();
    checks++; if (wr_strobe !== 0) begin errors++; $display("FAIL be_strobe_end got %h want 000", wr_strobe); end
    checks++; if (rd_valid !== 1 || data_out !== 16'hBE00) begin errors++; $display("FAIL be_read got %b/%h want 1/be00", rd_valid, data_out); end
    set(0, 0, 0, 0, 0, 0); tick();
    checks++; if (rd_valid !== 0 || data_out !== 16'hBE00) begin errors++; $display("FAIL be_read_hold got %b/%h want 0/be00", rd_valid, data_out); end
  endtask

  task automatic test_w1c();
    values_in[32] = 1; tick(); values_in[32] = 0;
    checks++; if (values_out[47:32] !== 16'h0001) begin errors++; $display("FAIL w1c_set got %h want 0001", values_out[47:32]); end
    tick();
    checks++; if (irq !== 1) begin errors++; $display("FAIL w1c_irq got %b want 1", irq); end
    values_in[32] = 1; set(1, 0, 1, 2'b11, 2, 16'h0001); tick(); values_in[32] = 0;
    checks++; if (values_out[47:32] !== 16'h0001) begin errors++; $display("FAIL w1c_set_wins got %h want 0001", values_out[47:32]); end
    tick();
    checks++; if (values_out[47:32] !== 16'h0000) begin errors++; $display("FAIL w1c_clear got %h want 0000", values_out[47:32]); end
    set(0, 0, 0, 0, 0, 0); tick();
    checks++; if (irq !== 0) begin errors++; $display("FAIL w1c_irq_clear got %b want 0", irq); end
    values_in[115] = 1; tick(); values_in[115] = 0;
    set(1, 0, 1, 2'b11, 7, 16'h0000); tick();
    checks++; if (values_out[127:112] !== 16'h0008) begin errors++; $display("FAIL w1c_over_rw got %h want 0008", values_out[127:112]); end
    set(1, 0, 1, 2'b11, 7, 16'h0008); tick(); set(0, 0, 0, 0, 0, 0); tick();
    checks++; if (values_out[127:112] !== 16'h0000 || irq !== 0) begin errors++; $display("FAIL w1c_r7_clear got %h/%b want 0000/0", values_out[127:112], irq); end
  endtask

  task automatic test_pulse();
    set(1, 0, 1, 2'b11, 3, 16'h0003); tick(); set(0, 0, 0, 0, 0, 0);
    checks++; if (values_out[63:48] !== 16'h0003) begin errors++; $display("FAIL pulse_hi got %h want 0003", values_out[63:48]); end
    tick();
    checks++; if (values_out[63:48] !== 16'h0000) begin errors++; $display("FAIL pulse_lo got %h want 0000", values_out[63:48]); end
    set(1, 0, 1, 2'b11, 3, 16'h0003); tick(); set(1, 0, 1, 2'b11, 3, 16'h0001); tick(); set(0, 0, 0, 0, 0, 0);
    checks++; if (values_out[63:48] !== 16'h0001) begin errors++; $display("FAIL pulse_reload got %h want 0001", values_out[63:48]); end
    tick();
    checks++; if (values_out[63:48] !== 16'h0000) begin errors++; $display("FAIL pulse_reload_lo got %h want 0000", values_out[63:48]); end
    set(1, 0, 1, 2'b11, 8, 16'h00FF); tick(); set(0, 0, 0, 0, 0, 0); tick();
    checks++; if (values_out[143:128] !== 16'h0000) begin errors++; $display("FAIL pulse_over_rw got %h want 0000", values_out[143:128]); end
  endtask

  task automatic test_ro_oor();
    values_in[15:0] = 16'h1234; set(1, 1, 0, 0, 0, 0); tick();
    checks++; if (rd_valid !== 1 || data_out !== 16'h1234) begin errors++; $display("FAIL ro_read got %b/%h want 1/1234", rd_valid, data_out); end
    set(1, 0, 1, 2'b11, 0, 16'hFFFF); tick();
    checks++; if (values_out[15:0] !== 16'h1234 || wr_strobe !== 12'h001) begin errors++; $display("FAIL ro_write got %h/%h want 1234/001", values_out[15:0], wr_strobe); end
    set(1, 1, 0, 0, 12, 0); tick();
    checks++; if (rd_valid !== 1 || data_out !== 16'h0000) begin errors++; $display("FAIL oor_read got %b/%h want 1/0000", rd_valid, data_out); end
    set(1, 0, 1, 2'b11, 13, 16'hFFFF); tick();
    checks++; if (wr_strobe !== 0 || values_out !== exp_vo()) begin errors++; $display("FAIL oor_write strobe %h want 000", wr_strobe); end
    set(1, 0, 1, 2'b11, 6, 16'hAAAA); tick(); set(1, 1, 1, 2'b11, 6, 16'h5555); tick();
    checks++; if (data_out !== 16'hAAAA || values_out[111:96] !== 16'h5555) begin errors++; $display("FAIL rd_wr_same got %h/%h want aaaa/5555", data_out, values_out[111:96]); end
  endtask

  task automatic test_reset_mid_read();
    reset = 1; set(1, 1, 0, 0, 6, 0); tick(); reset = 0; set(0, 0, 0, 0, 0, 0);
    checks++; if (rd_valid !== 0 || data_out !== 0) begin errors++; $display("FAIL rst_read got %b/%h want 0/0000", rd_valid, data_out); end
    checks++; if (values_out[111:96] !== 16'h1111 || values_out[95:80] !== 16'h0000) begin errors++; $display("FAIL rst_regs got %h/%h want 1111/0000", values_out[111:96], values_out[95:80]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = $urandom_range(0, 39) == 0;
      set($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom));
      for (int k = 0; k < 6; k++) values_in[32*k +: 32] = $urandom & $urandom & $urandom;
      tick();
      checks++; if (data_out !== exp_do || rd_valid !== exp_rv) begin errors++; $display("FAIL rnd_read n=%0d got %b/%h want %b/%h", n, rd_valid, data_out, exp_rv, exp_do); end
      checks++; if (wr_strobe !== exp_ws) begin errors++; $display("FAIL rnd_strobe n=%0d got %h want %h", n, wr_strobe, exp_ws); end
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL rnd_irq n=%0d got %b want %b", n, irq, exp_irq); end
      checks++; if (values_out !== exp_vo()) begin errors++; $display("FAIL rnd_values n=%0d got %h want %h", n, values_out, exp_vo()); end
    end
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mdl[i] = 0;
    test_reset();
    test_byte_enable();
    test_w1c();
    test_pulse();
    test_ro_oor();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
